pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generator at the head of the IF stage of the five-stage LA32R pipeline.
- Owns the architectural fetch PC and issues fetch requests to instruction memory over a valid/ready handshake.
- Advances sequentially by +4 and accepts redirects from EX (branch/jump).
- Stalls under control of the hazard unit.

Parameters:
- RESET_PC, 32'h1C00_0000, fetch address loaded on reset (LA32R reset vector).
- PC_WIDTH, 32, width of PC datapath; all arithmetic is modulo 2^PC_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit hold; freezes PC and drops req_valid.
- redirect_valid  input  1  EX-stage branch/jump taken this cycle.
- redirect_pc  input  PC_WIDTH  target address, sampled when redirect_valid=1.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  instruction memory accepts request.
- imem_req_pc  output  PC_WIDTH  fetch address of current request.
- if_pc  output  PC_WIDTH  PC of last accepted request, forwarded to the IF/ID register.
- if_pc_valid  output  1  one-cycle pulse: if_pc updated by an accepted request.

Behaviour:
- Reset (rst=1 at edge):
  - pc<=RESET_PC, state<=BOOT, imem_req_valid=0, if_pc=RESET_PC, if_pc_valid=0.
  - Reset asserted mid-handshake discards the outstanding request. No response is owed.
- States:
  - BOOT: single cycle, req_valid=0. Next state is RUN unconditionally, or REDIR if redirect_valid.
  - RUN: req_valid = ~stall & ~redirect_valid. imem_req_pc = pc.
  - REDIR: one bubble cycle, req_valid=0, pc already holds the target. Next state is RUN.
- Accept (fire) = imem_req_valid & imem_req_ready. On fire:
  - pc<=pc+4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
  - if_pc<=pc.
  - if_pc_valid<=1 for one cycle.
- Handshake stability: while imem_req_valid=1 and ready=0, imem_req_pc is held constant. The only exceptions are redirect and reset, which cancel the request.
- Stall: pc and if_pc hold, req_valid=0 that cycle. Stall never discards the PC, so the same address re-issues when stall drops.
- Redirect (any state):
  - pc<=redirect_pc, state<=REDIR, req_valid=0 in the redirect cycle itself. The in-flight request is cancelled, not accepted.
- Priority: rst > redirect_valid > stall > sequential advance.
  - redirect+stall together: redirect wins.
  - redirect while ready low: request withdrawn, target latched.
- Back-to-back redirects: each newer redirect overwrites pc and re-enters REDIR. The last target wins.
- Latency: the target is presented on imem_req_pc 2 cycles after the redirect cycle, with req_valid=1 there if no stall.
- Throughput: one request per cycle in RUN with ready=1 and no stall.

Optional Feature:
- Macro PC_GEN_ALIGN_CHECK_EN.
- When defined:
  - Adds output fetch_adef (1 bit, reset 0).
  - A redirect_pc with bits [1:0]!=0 sets fetch_adef=1 and forces state HALT (req_valid=0 permanently). pc holds the misaligned target for the exception unit to read.
  - Only rst exits HALT and clears the flag.
- When undefined:
  - No port and no HALT state.
  - redirect_pc[1:0] are forced to 2'b00 before loading.

Test Plan:
- Reset release with ready=1: BOOT bubble, then requests at 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles. if_pc_valid pulses track each fire.
- ready=0 for 3 cycles at pc=0x1C000004: imem_req_pc stable, req_valid=1 throughout. Then ready=1 gives one fire and pc advances to 0x1C000008.
- stall=1 for 2 cycles: req_valid=0, pc unchanged. After release the same pc re-issues and no address is skipped.
- redirect_valid=1 with redirect_pc=0x1C000100 while stall=1 and ready=0: request cancelled, one bubble, then request 0x1C000100 followed by 0x1C000104.
- pc=0xFFFFFFFC fire: next request 0x00000000.
- With PC_GEN_ALIGN_CHECK_EN, redirect to 0x1C000102: fetch_adef=1, req_valid stays 0, rst recovers to RESET_PC. Without the macro, the same redirect fetches 0x1C000100.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator at the head of the IF stage (LA32R, five-stage pipeline).
// Owns the architectural fetch PC and issues fetch requests to instruction memory over a
// valid/ready handshake. Advances by +4 per accepted request and takes redirects from EX.
//
// Ports:
//   clk             system clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   stall           hazard-unit hold: freezes PC and drops the request
//   redirect_valid  EX-stage branch/jump taken this cycle
//   redirect_pc     redirect target, sampled when redirect_valid=1
//   imem_req_valid  fetch request valid
//   imem_req_ready  instruction memory accepts the request
//   imem_req_pc     fetch address of the current request
//   if_pc           PC of the last accepted request, to the IF/ID register
//   if_pc_valid     one-cycle pulse when if_pc was updated by an accepted request
//   fetch_adef      (PC_GEN_ALIGN_CHECK_EN only) misaligned redirect seen, fetch halted
//
// Optional feature macro: PC_GEN_ALIGN_CHECK_EN. When defined, a redirect target with
// bits [1:0] != 0 halts fetch and raises fetch_adef until reset. When undefined, the
// low two target bits are cleared before loading.

module pc_gen #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = 32'h1C00_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_pc,
  output logic [PC_WIDTH-1:0] if_pc,
`ifdef PC_GEN_ALIGN_CHECK_EN
  output logic                fetch_adef,
`endif
  output logic                if_pc_valid
);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
`ifdef PC_GEN_ALIGN_CHECK_EN
    StHalt,
`endif
    StRedir
  } state_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] if_pc_q;
  logic                if_pc_valid_q;
  logic [PC_WIDTH-1:0] redirect_tgt;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                fire;

`ifdef PC_GEN_ALIGN_CHECK_EN
  logic                fetch_adef_q;
  logic                redirect_misaligned;

  // Keep the raw target so the exception unit can read the faulting address.
  assign redirect_tgt        = redirect_pc;
  assign redirect_misaligned = |redirect_pc[1:0];
  assign fetch_adef          = fetch_adef_q;
`else
  assign redirect_tgt = redirect_pc & ~PC_WIDTH'(3);
`endif

  // Redirect and reset both cancel the request in the cycle they are asserted.
  assign imem_req_valid = (state_q == StRun) & ~stall & ~redirect_valid & ~rst;
  assign fire           = imem_req_valid & imem_req_ready;
  assign pc_plus4       = pc_q + PC_WIDTH'(4);

  assign imem_req_pc = pc_q;
  assign if_pc       = if_pc_q;
  assign if_pc_valid = if_pc_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      if_pc_q       <= RESET_PC;
      if_pc_valid_q <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
      fetch_adef_q  <= 1'b0;
`endif
    end else begin
      if_pc_valid_q <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
      if (state_q == StHalt) begin
        // Only reset leaves HALT; pc keeps the faulting target.
        state_q <= StHalt;
      end else
`endif
      if (redirect_valid) begin
        pc_q    <= redirect_tgt;
        state_q <= StRedir;
`ifdef PC_GEN_ALIGN_CHECK_EN
        if (redirect_misaligned) begin
          state_q      <= StHalt;
          fetch_adef_q <= 1'b1;
        end
`endif
      end else begin
        unique case (state_q)
          StBoot:  state_q <= StRun;
          StRedir: state_q <= StRun;
          StRun: begin
            if (fire) begin
              pc_q          <= pc_plus4;
              if_pc_q       <= pc_q;
              if_pc_valid_q <= 1'b1;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a table of per-cycle input/expected-output records, plus
// hand-written sequences for wrap-around and the misaligned-redirect corner.
// Expected outputs are queued when a cycle's stimulus is driven and popped when sampled.

module tb_pc_gen;

  localparam logic [31:0] R = 32'h1C00_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_pc;
  logic [31:0] if_pc;
  logic        if_pc_valid;
`ifdef PC_GEN_ALIGN_CHECK_EN
  logic        fetch_adef;
`endif

  pc_gen #(
    .PC_WIDTH (32),
    .RESET_PC (R)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_pc    (imem_req_pc),
    .if_pc          (if_pc),
`ifdef PC_GEN_ALIGN_CHECK_EN
    .fetch_adef     (fetch_adef),
`endif
    .if_pc_valid    (if_pc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic        e_ifv;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] eifpc, input logic eifv);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.ready = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_ifpc = eifpc; v.e_ifv = eifv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cycle %0d %s: got %h expected %h", cyc, name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then sample outputs before the next rise.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst            = v.rst;
    stall          = v.stall;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    imem_req_ready = v.ready;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    check("req_valid",   {31'b0, imem_req_valid}, {31'b0, e.e_valid});
    check("req_pc",      imem_req_pc,             e.e_pc);
    check("if_pc",       if_pc,                   e.e_ifpc);
    check("if_pc_valid", {31'b0, if_pc_valid},    {31'b0, e.e_ifv});
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);

    //          rst stl rv  rpc               rdy  valid pc                 if_pc        ifv
    tbl.push_back(mk(1, 0, 0, 32'h0,          1,   0, R,                 R,           0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   0, R,                 R,           0)); // BOOT
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   1, R,                 R,           0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          0,   1, R + 4,             R,           1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          0,   1, R + 4,             R,           0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          0,   1, R + 4,             R,           0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   1, R + 4,             R,           0));
    tbl.push_back(mk(0, 1, 0, 32'h0,          1,   0, R + 8,             R + 4,       1));
    tbl.push_back(mk(0, 1, 0, 32'h0,          1,   0, R + 8,             R + 4,       0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   1, R + 8,             R + 4,       0));
    tbl.push_back(mk(0, 1, 1, R + 32'h100,    0,   0, R + 12,            R + 8,       1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   0, R + 32'h100,       R + 8,       0)); // REDIR
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   1, R + 32'h100,       R + 8,       0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   1, R + 32'h104,       R + 32'h100, 1));
    tbl.push_back(mk(0, 0, 1, 32'h2000_0000,  1,   0, R + 32'h108,       R + 32'h104, 1));
    tbl.push_back(mk(0, 0, 1, 32'h3000_0000,  1,   0, 32'h2000_0000,     R + 32'h104, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   0, 32'h3000_0000,     R + 32'h104, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,          1,   0, 32'h3000_0000,     R + 32'h104, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   1, 32'h3000_0000,     R + 32'h104, 0));
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC,  1,   0, 32'h3000_0004,     32'h3000_0000, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   0, 32'hFFFF_FFFC,     32'h3000_0000, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   1, 32'hFFFF_FFFC,     32'h3000_0000, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   1, 32'h0000_0000,     32'hFFFF_FFFC, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,          1,   0, 32'h0000_0004,     32'h0000_0000, 1));
    tbl.push_back(mk(0, 0, 1, R + 32'h200,    1,   0, R,                 R,           0)); // BOOT
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   0, R + 32'h200,       R,           0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          1,   1, R + 32'h200,       R,           0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Misaligned redirect.
    step(mk(0, 0, 1, 32'h1C00_0102, 1, 0, R + 32'h204, R + 32'h200, 1));
`ifdef PC_GEN_ALIGN_CHECK_EN
    step(mk(0, 0, 0, 32'h0, 1, 0, 32'h1C00_0102, R + 32'h200, 0));
    check("fetch_adef_set", {31'b0, fetch_adef}, 32'd1);
    step(mk(0, 0, 1, R,     1, 0, 32'h1C00_0102, R + 32'h200, 0));
    step(mk(0, 0, 0, 32'h0, 1, 0, 32'h1C00_0102, R + 32'h200, 0));
    check("fetch_adef_hold", {31'b0, fetch_adef}, 32'd1);
    step(mk(1, 0, 0, 32'h0, 1, 0, 32'h1C00_0102, R + 32'h200, 0));
    step(mk(0, 0, 0, 32'h0, 1, 0, R, R, 0));
    check("fetch_adef_clr", {31'b0, fetch_adef}, 32'd0);
    step(mk(0, 0, 0, 32'h0, 1, 1, R, R, 0));
`else
    step(mk(0, 0, 0, 32'h0, 1, 0, R + 32'h100, R + 32'h200, 0));
    step(mk(0, 0, 0, 32'h0, 1, 1, R + 32'h100, R + 32'h200, 0));
    step(mk(0, 0, 0, 32'h0, 1, 1, R + 32'h104, R + 32'h100, 1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
